// File: rtl/divider_seq_pkg.sv
// Shared constants for the sequential divider: default width and FSM encoding.
package divider_seq_pkg;
  localparam int N_DEFAULT = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOOP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/divider_seq_if.sv
// Request/result bundle of the divider. The master drives the operands and
// Start; the slave (the divider) returns quotient, remainder and status.
interface divider_seq_if
  import divider_seq_pkg::*;
#(
  parameter int n = N_DEFAULT
);
  logic         Start;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic [n-1:0] Q;
  logic [n-1:0] R;
  logic         Busy;
  logic         Done;
  logic         DivZero;

  modport master (output Start, A, B, input Q, R, Busy, Done, DivZero);
  modport slave  (input Start, A, B, output Q, R, Busy, Done, DivZero);
endinterface

// File: rtl/divider_seq_subtractk.sv
// k-bit unsigned subtractor. borrow is set when X < Y.
module subtractk #(
  parameter int k = 9
) (
  input  logic [k-1:0] X,
  input  logic [k-1:0] Y,
  output logic [k-1:0] D,
  output logic         borrow
);
  // One extra bit on both operands turns the carry-out into the borrow flag
  assign {borrow, D} = {1'b0, X} - {1'b0, Y};
endmodule

// File: rtl/divider_seq.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock.
// During LOOP the quotient register starts out holding the dividend and is
// shifted left into the remainder, so {R,Q} behaves as one 2n-bit shifter.
module divider_seq
  import divider_seq_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic          Clock,
  input  logic          Resetn,
  divider_seq_if.slave  bus
);
  localparam int CW = $clog2(n);

  logic [1:0]    r_state;
  logic [n-1:0]  r_b;
  logic [n-1:0]  r_q;
  logic [n-1:0]  r_r;
  logic [CW-1:0] r_cnt;
  logic          r_dz;

  logic [n:0]    w_rsh;
  logic [n:0]    w_diff_full;
  logic [n-1:0]  w_diff;
  logic          w_diff_msb_unused;
  logic          w_borrow;

  // Remainder shifted left with the next dividend bit brought in from Q
  assign w_rsh = {r_r, r_q[n-1]};

  subtractk #(.k(n+1)) u_sub (
    .X      (w_rsh),
    .Y      ({1'b0, r_b}),
    .D      (w_diff_full),
    .borrow (w_borrow)
  );

  // When there is no borrow the difference is below B, so its MSB is always 0
  assign w_diff            = w_diff_full[n-1:0];
  assign w_diff_msb_unused = w_diff_full[n];

  // FSM plus datapath registers; a zero divisor bypasses LOOP entirely
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
      r_b     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_b   <= bus.B;
            r_cnt <= CW'(n-1);
            if (bus.B == '0) begin
              r_q     <= '1;
              r_r     <= bus.A;
              r_dz    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_q     <= bus.A;
              r_r     <= '0;
              r_state <= LOOP;
            end
          end
        end
        LOOP: begin
          r_q   <= {r_q[n-2:0], ~w_borrow};
          r_r   <= w_borrow ? w_rsh[n-1:0] : w_diff;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= DONE;
        end
        DONE: begin
          // Held Start parks here so it cannot retrigger a new division
          if (!bus.Start) begin
            r_state <= IDLE;
            r_dz    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_dz    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Q       = r_q;
  assign bus.R       = r_r;
  assign bus.Busy    = (r_state == LOOP);
  assign bus.Done    = (r_state == DONE);
  assign bus.DivZero = r_dz;
endmodule

// File: tb/tb_divider_seq.sv
// Directed and randomized checks of divider_seq with a result scoreboard.
module tb_divider_seq;
  import divider_seq_pkg::*;

  localparam int N = 8;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;
  int   tests  = 0;
  int   fails  = 0;
  exp_t sb[$];

  divider_seq_if #(.n(N)) bus();
  divider_seq #(.n(N)) dut (.Clock(Clock), .Resetn(Resetn), .bus(bus));

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t m;
    if (b == '0) begin
      m.q = '1; m.r = a; m.dz = 1'b1;
    end else begin
      m.q = a / b; m.r = a % b; m.dz = 1'b0;
    end
    return m;
  endfunction

  task automatic check_result(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_q"},  32'(bus.Q),       32'(e.q));
    chk({tag, "_r"},  32'(bus.R),       32'(e.r));
    chk({tag, "_dz"}, 32'(bus.DivZero), 32'(e.dz));
  endtask

  // One-cycle Start; edges counts clocks after the Start-sampling edge until Done
  task automatic do_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        output int edges, output int busyc);
    sb.push_back(model(a, b));
    bus.A = a; bus.B = b; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    edges = 0; busyc = 0;
    while (!bus.Done && edges < 40) begin
      if (bus.Busy) busyc++;
      tick();
      edges++;
    end
    chk({tag, "_done_seen"}, 32'(bus.Done), 1);
    check_result(tag);
  endtask

  initial begin
    int ed, bc, rises, bad;
    logic prev_done;
    logic [N-1:0] ra, rb;
    logic [31:0] prod;

    bus.Start = 1'b0; bus.A = '0; bus.B = '0;
    repeat (2) tick();
    chk("rst_q",    32'(bus.Q), 0);
    chk("rst_r",    32'(bus.R), 0);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_dz",   32'(bus.DivZero), 0);
    @(negedge Clock) Resetn = 1'b1;
    tick();

    // Test 1: 100/7
    do_div("t1", 8'd100, 8'd7, ed, bc);
    chk("t1_edges", 32'(ed), 8);
    chk("t1_busy_cycles", 32'(bc), 8);
    chk("t1_q_const", 32'(bus.Q), 14);
    chk("t1_r_const", 32'(bus.R), 2);
    tick();
    chk("t1_idle_done", 32'(bus.Done), 0);
    chk("t1_idle_busy", 32'(bus.Busy), 0);
    tick();
    chk("t1_hold_q", 32'(bus.Q), 14);
    chk("t1_hold_r", 32'(bus.R), 2);

    // Test 2: boundary quotients
    do_div("t2a", 8'd255, 8'd1, ed, bc);
    chk("t2a_q_const", 32'(bus.Q), 255);
    tick();
    do_div("t2b", 8'd5, 8'd9, ed, bc);
    chk("t2b_r_const", 32'(bus.R), 5);
    tick();

    // Test 3: divide by zero goes straight to DONE on the Start edge
    do_div("t3", 8'd37, 8'd0, ed, bc);
    chk("t3_edges", 32'(ed), 0);
    chk("t3_busy_cycles", 32'(bc), 0);
    chk("t3_q_const", 32'(bus.Q), 255);
    tick();
    chk("t3_dz_clear", 32'(bus.DivZero), 0);
    chk("t3_idle_done", 32'(bus.Done), 0);

    // Test 4: asynchronous reset mid-LOOP
    bus.A = 8'd200; bus.B = 8'd3; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    repeat (4) tick();
    chk("t4_in_loop", 32'(bus.Busy), 1);
    Resetn = 1'b0;
    #1;
    chk("t4_rst_q",    32'(bus.Q), 0);
    chk("t4_rst_r",    32'(bus.R), 0);
    chk("t4_rst_busy", 32'(bus.Busy), 0);
    chk("t4_rst_done", 32'(bus.Done), 0);
    chk("t4_rst_dz",   32'(bus.DivZero), 0);
    tick();
    @(negedge Clock) Resetn = 1'b1;
    tick();
    chk("t4_idle_busy", 32'(bus.Busy), 0);
    do_div("t4", 8'd200, 8'd3, ed, bc);
    chk("t4_q_const", 32'(bus.Q), 66);
    chk("t4_r_const", 32'(bus.R), 2);
    tick();

    // Test 5: Start held for 20 cycles, operands changed mid-LOOP
    sb.push_back(model(8'd50, 8'd6));
    bus.A = 8'd50; bus.B = 8'd6; bus.Start = 1'b1;
    bc = 0; rises = 0; bad = 0; prev_done = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (cyc == 3) begin bus.A = 8'd201; bus.B = 8'd13; end
      if (bus.Busy) bc++;
      if (bus.Done && !prev_done) rises++;
      if (bus.Done && (bus.Q !== 8'd8 || bus.R !== 8'd2)) bad++;
      prev_done = bus.Done;
    end
    chk("t5_busy_cycles", 32'(bc), 8);
    chk("t5_done_rises", 32'(rises), 1);
    chk("t5_done_held", 32'(bus.Done), 1);
    chk("t5_unstable_cycles", 32'(bad), 0);
    check_result("t5");
    bus.Start = 1'b0;
    tick();
    chk("t5_done_drop", 32'(bus.Done), 0);
    tick();

    // Test 6: random operands, identity A = Q*B + R with R < B
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      do_div("t6", ra, rb, ed, bc);
      prod = 32'(bus.Q) * 32'(rb) + 32'(bus.R);
      chk("t6_identity", prod, 32'(ra));
      chk("t6_r_lt_b", 32'(bus.R < rb), 1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 The block SHALL have parameter n, default 8, operand and result width in bits (n >= 2).
REQ-002 The block SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Resetn, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port Start, input, 1, request a division using the current A and B.
REQ-005 The block SHALL have port A, input, n, unsigned dividend.
REQ-006 The block SHALL have port B, input, n, unsigned divisor.
REQ-007 The block SHALL have port Q, output, n, registered quotient.
REQ-008 The block SHALL have port R, output, n, registered remainder.
REQ-009 The block SHALL have port Busy, output, 1, high while an iteration is in progress.
REQ-010 The block SHALL have port Done, output, 1, high while Q and R hold a valid result.
REQ-011 The block SHALL have port DivZero, output, 1, high with Done when B was 0.

Function
REQ-012 The block SHALL implement an unsigned restoring shift-subtract divider with FSM states IDLE, LOOP and DONE.
REQ-013 In IDLE, a rising edge with Start=1 SHALL register A and B, clear the remainder register, load the iteration counter with n-1 and enter LOOP; if B=0, it SHALL enter DONE directly instead.
REQ-014 Each LOOP edge SHALL shift {R,Q} left by one bit, bringing in the dividend MSB, and trial-compute R_shifted - B with an (n+1)-bit borrow.
REQ-015 If there is no borrow, a LOOP edge SHALL keep the difference as R and set the new Q LSB to 1; otherwise it SHALL keep R_shifted and set the new Q LSB to 0.
REQ-016 LOOP SHALL last exactly n edges; the edge with counter=0 SHALL enter DONE, so Done rises n edges after the Start-sampling edge.
REQ-017 On the divide-by-zero path, DONE SHALL be reached 1 edge after Start, with Q set to all ones, R set to the registered A and DivZero set to 1.
REQ-018 Busy SHALL be 1 exactly in LOOP; Done SHALL be 1 exactly in DONE; DivZero SHALL be 0 outside DONE.
REQ-019 Q and R SHALL be stable throughout DONE and SHALL hold their last values in IDLE until the next Start.
REQ-020 The block SHALL remain in DONE while Start=1 and SHALL return to IDLE on the first edge with Start=0, so a held Start never retriggers.
REQ-021 Start SHALL be ignored in LOOP, and A/B changes during LOOP or DONE SHALL have no effect on the result.
REQ-022 Results SHALL satisfy A = Q*B + R with R < B for every B != 0.

Reset
REQ-023 Resetn=0 SHALL immediately force state IDLE, with Q, R, internal operand registers and the counter at 0, and Busy, Done and DivZero at 0.
REQ-024 Reset asserted mid-LOOP or in DONE SHALL abort the operation with no partial result retained.
REQ-025 After Resetn deasserts, the first Start SHALL begin a fresh division.

Structure
REQ-026 The state encoding constants (IDLE, LOOP, DONE) and the default width SHALL reside in a shared package.
REQ-027 The trial subtraction SHALL be one sub-module, subtractk (parameter k, inputs X and Y, outputs D and borrow), instantiated at width n+1.
REQ-028 The FSM and the datapath registers SHALL be in the top module.

Verification
REQ-029 Test 1: with n=8, A=100, B=7 and a one-cycle Start -> after 8 edges Done=1, Q=14, R=2, DivZero=0; Busy is high for exactly 8 cycles.
REQ-030 Test 2: A=255, B=1 -> Q=255, R=0; then A=5, B=9 -> Q=0, R=5.
REQ-031 Test 3: A=37, B=0 -> Done=1 after 1 edge, Q=255, R=37, DivZero=1, Busy never high.
REQ-032 Test 4: Resetn pulsed low at LOOP edge 4 of 200/3 -> outputs are immediately 0 and state is IDLE; a new division 200/3 then gives Q=66, R=2.
REQ-033 Test 5: Start held high for 20 cycles with 50/6 -> a single result Q=8, R=2 with Done held; Done drops 1 edge after Start falls; A/B changed mid-LOOP do not alter the result.
REQ-034 Test 6: randomized A and B over 500 runs -> the REQ-022 identity holds for each run.
